// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC psum sequencing / accumulation path.
package mac_pkg;

   localparam int CFG_LEN_W  = 7;
   localparam int CFG_PASS_W = 12;
   localparam int CFG_TILE_W = 16;
   localparam int PSUM_DEPTH = 64;

   typedef enum logic {
      SEQ_IDLE,
      SEQ_RUN
   } seq_state_e;

   typedef struct packed {
      logic [CFG_LEN_W-1:0]  tile_len;
      logic [CFG_PASS_W-1:0] num_pass;
      logic [CFG_TILE_W-1:0] num_tile;
   } acc_seq_cfg_t;

endpackage

// File: rtl/mac_nested_counter.sv
// Three-level wrap counter (inner, middle, outer) with per-level terminal flags.
module mac_nested_counter #(
   parameter int W0 = 7,
   parameter int W1 = 12,
   parameter int W2 = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [W0-1:0] i_max0,
   input  logic [W1-1:0] i_max1,
   input  logic [W2-1:0] i_max2,
   output logic [W1-1:0] o_cnt1,
   output logic [W2-1:0] o_cnt2,
   output logic          o_last0,
   output logic          o_last1,
   output logic          o_last2
);

   logic [W0-1:0] r_cnt0;
   logic [W1-1:0] r_cnt1;
   logic [W2-1:0] r_cnt2;

   assign o_last0 = (r_cnt0 == i_max0);
   assign o_last1 = (r_cnt1 == i_max1);
   assign o_last2 = (r_cnt2 == i_max2);
   assign o_cnt1  = r_cnt1;
   assign o_cnt2  = r_cnt2;

   // Wrapping all three levels at once leaves every counter at zero.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
         r_cnt2 <= '0;
      end else if (i_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
         r_cnt2 <= '0;
      end else if (i_en) begin
         if (o_last0) begin
            r_cnt0 <= '0;
            if (o_last1) begin
               r_cnt1 <= '0;
               r_cnt2 <= o_last2 ? '0 : r_cnt2 + 1'b1;
            end else begin
               r_cnt1 <= r_cnt1 + 1'b1;
            end
         end else begin
            r_cnt0 <= r_cnt0 + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_accum_sequencer.sv
// Psum pass-through between MAC array and accumulator; sequences one job and
// generates the per-element inter_end / accum_end flags.
module mac_accum_sequencer #(
   parameter int DATA_W     = 32,
   parameter int LEN_W      = mac_pkg::CFG_LEN_W,
   parameter int PASS_W     = mac_pkg::CFG_PASS_W,
   parameter int TILE_W     = mac_pkg::CFG_TILE_W,
   parameter int PSUM_DEPTH = mac_pkg::PSUM_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic [LEN_W-1:0]  i_cfg_tile_len,
   input  logic [PASS_W-1:0] i_cfg_num_pass,
   input  logic [TILE_W-1:0] i_cfg_num_tile,
   input  logic              i_psum_valid,
   output logic              o_psum_ready,
   input  logic [DATA_W-1:0] i_psum_data,
   output logic              o_acc_psum_valid,
   input  logic              i_acc_psum_ready,
   output logic [DATA_W-1:0] o_acc_psum_data,
   output logic              o_acc_inter_end,
   output logic              o_acc_accum_end,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_cfg_err,
   output logic [PASS_W-1:0] o_pass_idx,
   output logic [TILE_W-1:0] o_tile_idx
);

   import mac_pkg::*;

   seq_state_e   r_state;
   seq_state_e   w_state_nxt;
   acc_seq_cfg_t r_cfg;
   logic         r_done;
   logic         r_cfg_err;

   logic w_cfg_legal;
   logic w_cfg_acc;
   logic w_cfg_bad;
   logic w_fire;
   logic w_last_elem;
   logic w_last_pass;
   logic w_last_tile;
   logic w_job_end;

   assign w_cfg_legal = (i_cfg_tile_len != '0) && (i_cfg_num_pass != '0) &&
                        (i_cfg_num_tile != '0) && (int'(i_cfg_tile_len) <= PSUM_DEPTH);

   always_comb begin
      w_state_nxt      = r_state;
      o_cfg_ready      = 1'b0;
      o_psum_ready     = 1'b0;
      o_acc_psum_valid = 1'b0;
      o_busy           = 1'b0;
      w_fire           = 1'b0;
      w_cfg_acc        = 1'b0;
      w_cfg_bad        = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            o_cfg_ready = 1'b1;
            if (i_cfg_valid) begin
               if (w_cfg_legal) begin
                  w_cfg_acc   = 1'b1;
                  w_state_nxt = SEQ_RUN;
               end else begin
                  w_cfg_bad = 1'b1;
               end
            end
         end
         SEQ_RUN: begin
            o_busy           = 1'b1;
            o_acc_psum_valid = i_psum_valid;
            o_psum_ready     = i_acc_psum_ready;
            w_fire           = i_psum_valid & i_acc_psum_ready;
            if (w_fire && w_last_elem && w_last_pass && w_last_tile) begin
               w_state_nxt = SEQ_IDLE;
            end
         end
         default: w_state_nxt = SEQ_IDLE;
      endcase
   end

   assign w_job_end       = w_fire & w_last_elem & w_last_pass & w_last_tile;
   assign o_acc_psum_data = i_psum_data;
   assign o_acc_inter_end = w_fire & w_last_elem;
   assign o_acc_accum_end = w_fire & w_last_pass;
   assign o_done          = r_done;
   assign o_cfg_err       = r_cfg_err;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= SEQ_IDLE;
         r_cfg     <= '0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_done    <= w_job_end | w_cfg_bad;
         r_cfg_err <= w_cfg_bad;
         if (w_cfg_acc) begin
            r_cfg <= '{tile_len: i_cfg_tile_len, num_pass: i_cfg_num_pass,
                       num_tile: i_cfg_num_tile};
         end
      end
   end

   mac_nested_counter #(
      .W0 (LEN_W),
      .W1 (PASS_W),
      .W2 (TILE_W)
   ) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_cfg_acc),
      .i_en    (w_fire),
      .i_max0  (r_cfg.tile_len - LEN_W'(1)),
      .i_max1  (r_cfg.num_pass - PASS_W'(1)),
      .i_max2  (r_cfg.num_tile - TILE_W'(1)),
      .o_cnt1  (o_pass_idx),
      .o_cnt2  (o_tile_idx),
      .o_last0 (w_last_elem),
      .o_last1 (w_last_pass),
      .o_last2 (w_last_tile)
   );

endmodule

// File: tb/tb_mac_accum_sequencer.sv
// Directed bench for mac_accum_sequencer: flag positions, config errors, abort, back-to-back.
module tb_mac_accum_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [6:0]  cfg_tile_len;
   logic [11:0] cfg_num_pass;
   logic [15:0] cfg_num_tile;
   logic        psum_valid;
   logic        psum_ready;
   logic [31:0] psum_data;
   logic        acc_valid;
   logic        acc_ready;
   logic [31:0] acc_data;
   logic        inter_end;
   logic        accum_end;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [11:0] pass_idx;
   logic [15:0] tile_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_accum_sequencer #(
      .DATA_W     (32),
      .LEN_W      (7),
      .PASS_W     (12),
      .TILE_W     (16),
      .PSUM_DEPTH (64)
   ) dut (
      .i_clk            (clk),
      .i_reset          (rst_n),
      .i_cfg_valid      (cfg_valid),
      .o_cfg_ready      (cfg_ready),
      .i_cfg_tile_len   (cfg_tile_len),
      .i_cfg_num_pass   (cfg_num_pass),
      .i_cfg_num_tile   (cfg_num_tile),
      .i_psum_valid     (psum_valid),
      .o_psum_ready     (psum_ready),
      .i_psum_data      (psum_data),
      .o_acc_psum_valid (acc_valid),
      .i_acc_psum_ready (acc_ready),
      .o_acc_psum_data  (acc_data),
      .o_acc_inter_end  (inter_end),
      .o_acc_accum_end  (accum_end),
      .o_busy           (busy),
      .o_done           (done),
      .o_cfg_err        (cfg_err),
      .o_pass_idx       (pass_idx),
      .o_tile_idx       (tile_idx)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_acc_valid", 32'(acc_valid), 32'd0);
      chk("rst_psum_ready", 32'(psum_ready), 32'd0);
      chk("rst_flags", 32'({inter_end, accum_end}), 32'd0);
      chk("rst_pass_idx", 32'(pass_idx), 32'd0);
      chk("rst_tile_idx", 32'(tile_idx), 32'd0);
   endtask

   // Entered and left at posedge+1.
   task automatic apply_cfg(input int l, input int p, input int t);
      cfg_valid    = 1'b1;
      cfg_tile_len = 7'(l);
      cfg_num_pass = 12'(p);
      cfg_num_tile = 16'(t);
      psum_valid   = 1'b0;
      @(negedge clk);
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic bad_cfg(input int l, input int p, input int t);
      cfg_valid    = 1'b1;
      cfg_tile_len = 7'(l);
      cfg_num_pass = 12'(p);
      cfg_num_tile = 16'(t);
      psum_valid   = 1'b1;
      acc_ready    = 1'b1;
      @(negedge clk);
      chk("bad_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("bad_psum_ready0", 32'(psum_ready), 32'd0);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("bad_cfg_err", 32'(cfg_err), 32'd1);
      chk("bad_done", 32'(done), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_psum_ready1", 32'(psum_ready), 32'd0);
      chk("bad_acc_valid", 32'(acc_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bad_err_pulse", 32'({cfg_err, done, busy}), 32'd0);
      @(posedge clk); #1;
      psum_valid = 1'b0;
   endtask

   // Streams until `stop_after` transfers (0 = whole job), checking every cycle.
   task automatic run_stream(input int l, input int p, input int t, input bit gaps,
                             input int stop_after);
      int total;
      int target;
      int k;
      int budget;
      bit fire;
      total  = l * p * t;
      target = (stop_after != 0) ? stop_after : total;
      k      = 0;
      budget = 0;
      while (k < target && budget < 2000) begin
         psum_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         acc_ready  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         psum_data  = $urandom;
         @(negedge clk);
         fire = psum_valid & acc_ready;
         chk("busy", 32'(busy), 32'd1);
         chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
         chk("acc_valid", 32'(acc_valid), 32'(psum_valid));
         chk("psum_ready", 32'(psum_ready), 32'(acc_ready));
         chk("acc_data", acc_data, psum_data);
         if (fire) begin
            chk("inter_end", 32'(inter_end), 32'((k % l) == l - 1));
            chk("accum_end", 32'(accum_end), 32'(((k / l) % p) == p - 1));
            chk("pass_idx", 32'(pass_idx), 32'((k / l) % p));
            chk("tile_idx", 32'(tile_idx), 32'(k / (l * p)));
            k++;
         end else begin
            chk("idle_flags", 32'({inter_end, accum_end}), 32'd0);
         end
         @(posedge clk); #1;
         budget++;
      end
      if (k < target) chk("stream_timeout", 32'(k), 32'(target));
      if (target == total) begin
         psum_valid = 1'b1;
         acc_ready  = 1'b1;
         @(negedge clk);
         chk("done_pulse", 32'(done), 32'd1);
         chk("done_busy", 32'(busy), 32'd0);
         chk("done_cfg_ready", 32'(cfg_ready), 32'd1);
         chk("done_cfg_err", 32'(cfg_err), 32'd0);
         chk("done_acc_valid", 32'(acc_valid), 32'd0);
         chk("done_flags", 32'({inter_end, accum_end}), 32'd0);
         @(posedge clk); #1;
         cfg_valid  = 1'b0;
         psum_valid = 1'b0;
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      cfg_valid    = 1'b0;
      cfg_tile_len = '0;
      cfg_num_pass = '0;
      cfg_num_tile = '0;
      psum_valid   = 1'b0;
      psum_data    = '0;
      acc_ready    = 1'b0;
      #12;
      chk_reset_state();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_cfg(4, 3, 2);
      run_stream(4, 3, 2, 1'b0, 0);

      apply_cfg(64, 1, 1);
      run_stream(64, 1, 1, 1'b0, 0);

      apply_cfg(4, 3, 2);
      run_stream(4, 3, 2, 1'b1, 0);

      bad_cfg(65, 1, 1);
      bad_cfg(4, 0, 2);

      apply_cfg(4, 3, 2);
      run_stream(4, 3, 2, 1'b0, 10);
      psum_valid = 1'b1;
      acc_ready  = 1'b1;
      rst_n      = 1'b0;
      #1;
      chk_reset_state();
      @(posedge clk); #1;
      rst_n      = 1'b1;
      psum_valid = 1'b0;
      @(posedge clk); #1;
      apply_cfg(2, 2, 1);
      run_stream(2, 2, 1, 1'b0, 0);

      // Second config held pending while the first job runs.
      apply_cfg(4, 1, 2);
      cfg_valid    = 1'b1;
      cfg_tile_len = 7'd3;
      cfg_num_pass = 12'd2;
      cfg_num_tile = 16'd1;
      run_stream(4, 1, 2, 1'b0, 0);
      run_stream(3, 2, 1, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
